// File: rtl/ecpeta_error_monitor_if.sv
// Sample stream into the ECPETA error monitor: operands, approximate sum and valid/ready.
interface ecpeta_error_monitor_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum_approx;

    // Producer side: the adder harness driving samples.
    modport master (
        output in_valid,
        output a,
        output b,
        output sum_approx,
        input  in_ready
    );

    // Consumer side: the error monitor.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sum_approx,
        output in_ready
    );
endinterface

// File: rtl/ecpeta_error_monitor.sv
// Error-statistics collector for the ECPETA approximate adder: accepts
// (a, b, sum_approx) samples, measures error distance against the exact
// N-bit sum and accumulates count / error count / ED sum / ED max.
module ecpeta_error_monitor #(
    parameter int unsigned N     = 16,
    parameter int unsigned K     = 8,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    ecpeta_error_monitor_if.slave smp,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [ACC_W-1:0]     ed_sum,
    output logic [N-1:0]         ed_max,
    output logic [N-1:0]         last_ed,
    output logic                 sat,
    output logic                 busy,
    output logic                 done
);

    // K only describes the adder under test; reject nonsensical configurations.
    if (K > N) begin : g_k_range
        $error("ecpeta_error_monitor: K must not exceed N");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic                 accept_c;
    logic [N-1:0]         exact_c;
    logic signed [N:0]    diff_c;
    logic [N-1:0]         ed_c;

    logic                 s1_valid;
    logic [N-1:0]         s1_ed;

    logic                 err_hit_c;
    logic                 cnt_ovf_c;
    logic                 err_ovf_c;
    logic [ACC_W:0]       sum_ext_c;
    logic                 sum_ovf_c;

    // A start cycle never accepts: it invalidates the pipeline instead.
    assign accept_c = smp.in_valid && smp.in_ready && !start;

    // Error distance: carry-out of the exact sum is dropped, magnitude of the signed difference.
    always_comb begin
        exact_c = smp.a + smp.b;
        diff_c  = $signed({1'b0, exact_c}) - $signed({1'b0, smp.sum_approx});
        ed_c    = diff_c[N] ? N'(-diff_c) : N'(diff_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; start overrides everything, including a simultaneous stop.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  state_n = S_IDLE;
            S_RUN:   if (stop) state_n = S_DRAIN;
            S_DRAIN: if (!s1_valid) state_n = S_DONE;
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (start) begin
            state_n = S_RUN;
        end
    end

    // Registered status outputs, aligned with the state after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            smp.in_ready <= (state_n == S_RUN);
            busy         <= (state_n == S_RUN) || (state_n == S_DRAIN);
            done         <= (state_n == S_DONE);
        end
    end

    // Stage 1: hold the error distance of the accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else if (start) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_ed <= ed_c;
            end
        end
    end

    // Saturation detection for the commit of stage 1.
    always_comb begin
        err_hit_c = (s1_ed != '0);
        cnt_ovf_c = &sample_count;
        err_ovf_c = err_hit_c && (&err_count);
        sum_ext_c = {1'b0, ed_sum} + (ACC_W + 1)'(s1_ed);
        sum_ovf_c = sum_ext_c[ACC_W];
    end

    // Stage 2: commit to the statistics with clamping counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            last_ed      <= '0;
            sat          <= 1'b0;
        end else if (start) begin
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            last_ed      <= '0;
            sat          <= 1'b0;
        end else if (s1_valid) begin
            if (!cnt_ovf_c) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (err_hit_c && !err_ovf_c) begin
                err_count <= err_count + CNT_W'(1);
            end
            ed_sum  <= sum_ovf_c ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
            ed_max  <= (s1_ed > ed_max) ? s1_ed : ed_max;
            last_ed <= s1_ed;
            if (cnt_ovf_c || err_ovf_c || sum_ovf_c) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ecpeta_error_monitor.md
# ecpeta_error_monitor

Sequential error-statistics collector for the ECPETA approximate adder. It sits at the output side of the adder under evaluation and accepts a stream of (A, B, approximate sum) samples over a valid/ready handshake. For each sample it computes the exact N-bit sum and the error distance. It accumulates the sample count, the erroneous-sample count, the summed error distance and the maximum error distance, which gives error rate and mean/max error distance for characterisation runs.

## Interface
- N, 16, operand and sum width, matching the adder's n
- K, 8, approximate-part width, reporting only; no effect on logic
- CNT_W, 32, width of sample_count and err_count
- ACC_W, 48, width of ed_sum
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears statistics and enters RUN
- stop  in  1  pulse; ends collection and drains the pipeline
- in_valid  in  1  sample valid
- in_ready  out  1  monitor can accept a sample
- a  in  N  operand A
- b  in  N  operand B
- sum_approx  in  N  adder output for (a, b)
- sample_count  out  CNT_W  samples committed
- err_count  out  CNT_W  committed samples with ed ≠ 0
- ed_sum  out  ACC_W  sum of error distances
- ed_max  out  N  largest error distance seen
- last_ed  out  N  error distance of the most recent committed sample
- sat  out  1  sticky; some counter or accumulator saturated
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE

## Operation
- Exact reference: exact = (a + b) mod 2^N, so carry-out is discarded and only approximation error is measured.
- Error distance: ed = |exact − sum_approx|, computed as an (N+1)-bit signed difference, then magnitude, N bits unsigned.
- States: IDLE, RUN, DRAIN, DONE. in_ready = 1 only in RUN.
- IDLE: start → RUN. stop is ignored.
- RUN: stop → DRAIN.
- DRAIN: go to DONE on the edge after the stage-1 valid bit is 0, so that all accepted samples are committed.
- DONE: hold all statistics. start → RUN.
- start in any state:
  - zeroes sample_count, err_count, ed_sum, ed_max, last_ed and sat;
  - invalidates the pipeline, so an in-flight sample is discarded and not committed;
  - sets state to RUN.
- start and stop asserted in the same cycle: start wins.
- Handshake: a sample is accepted on a rising edge where in_valid && in_ready. a, b and sum_approx are sampled only then. A stop asserted in the same cycle does not reject that sample.
- Pipeline:
  - Stage 1 registers the accepted sample and its ed.
  - Stage 2 commits stage 1 to the statistics.
- Commit actions:
  - sample_count += 1;
  - err_count += (ed ≠ 0);
  - ed_sum += ed;
  - ed_max = max(ed_max, ed);
  - last_ed = ed.
- Saturation: each counter and accumulator clamps at all-ones instead of wrapping. sat is set on the commit that would have overflowed. The other fields keep updating.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, pipeline invalid, every output 0 (in_ready, busy, done, sat, all counters, ed_sum, ed_max, last_ed).
- Latency: a sample accepted on edge E is visible on the statistics outputs after edge E+1.
- Throughput: one sample per cycle in RUN, with no bubbles.
- in_ready deasserts on the edge that leaves RUN.
- From stop accepted on edge S:
  - DRAIN after S;
  - DONE after S+2 if a sample was in stage 1, otherwise after S+1.
- busy and done are registered and consistent with the state after each edge.
- start issued in DONE: clears happen on the start edge, and in_ready = 1 from the next cycle.

## Test plan
- Reset mid-RUN with a sample in stage 1: assert rst_n = 0 asynchronously → all outputs 0 immediately, state IDLE. After release, in_ready stays 0 until start.
- start, then 4 back-to-back samples:
  - (0x1234, 0x5678, 0x68AC)
  - (0xFFFF, 0x0001, 0x00FF)
  - (0xAAAA, 0x5555, 0xFFF0)
  - (0x0000, 0x0000, 0x0000)
  - then stop.
  - Required: sample_count = 4, err_count = 2, ed_sum = 270, ed_max = 255, last_ed = 0, done = 1.
- Sign of difference: sample (0x0F0F, 0xF0F0, 0x0000) → exact 0xFFFF, ed = 0xFFFF, ed_max = 0xFFFF. Then sample (0x0001, 0x0001, 0x0005) → ed = 3, last_ed = 3.
- Latency and drain:
  - a sample accepted in the same cycle as stop is committed, and done rises exactly 2 edges after the stop edge;
  - in_valid held high in DRAIN/DONE accepts nothing.
- Restart and discard: start asserted while a sample sits in stage 1 → that sample is not counted, and all statistics read 0 after the start edge. start and stop together → RUN.
- Saturation: with CNT_W = 2 as a parameter override, 5 erroneous samples → sample_count = err_count = 3 and sat = 1. sat stays 1 until the next start.
